freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 50_000_000: gate window length in clk cycles; legal range 2 to 2^32-1.
REQ-002 Parameter CNT_W, default 32: width of the edge counter and the freq output.
REQ-003 Port clk  input  1: single system clock; all state updates on rising edge.
REQ-004 Port rst  input  1: asynchronous reset, active-high; clears all state immediately on assertion.
REQ-005 Port sig_in  input  1: signal under measurement, asynchronous to clk.
REQ-006 Port start  input  1: single-cycle request for one measurement; sampled only in IDLE.
REQ-007 Port continuous  input  1: level; while high, measurements repeat back-to-back.
REQ-008 Port busy  output  1: high in GATE and DONE states.
REQ-009 Port freq  output  CNT_W: rising-edge count of the last completed window; holds between windows.
REQ-010 Port valid  output  1: one-cycle pulse when freq updates.
REQ-011 Port overflow  output  1: saturation flag for the last completed window; updates with freq.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer (s1, s2), plus one history flop s3; rising edge = s2 & ~s3.
REQ-013 Synchronizer and history flops SHALL run in every state, so edge detection is valid on the first GATE cycle.
REQ-014 FSM states SHALL be IDLE, GATE and DONE.
REQ-015 IDLE -> GATE when start=1 or continuous=1 in the same cycle; edge counter and gate counter clear to 0 on this transition.
REQ-016 In GATE, gate counter SHALL increment each cycle; GATE -> DONE in the cycle gate counter equals GATE_CYCLES-1.
REQ-017 Edge counter SHALL increment once per detected rising edge in every GATE cycle, including the final one; edges outside GATE are ignored.
REQ-018 Edge counter SHALL saturate at 2^CNT_W-1; any edge arriving at saturation sets an internal sticky ovf bit for the current window.
REQ-019 In DONE (exactly 1 cycle), freq <= edge counter, overflow <= ovf, and valid SHALL be 1.
REQ-020 DONE -> GATE if continuous=1, clearing both counters and ovf, so no clk cycle is lost between gates beyond the DONE cycle; otherwise DONE -> IDLE.
REQ-021 start asserted in GATE or DONE SHALL be ignored (not queued).
REQ-022 continuous deasserting mid-GATE SHALL let the current window finish normally, then return to IDLE.
REQ-023 Latency: a sig_in edge SHALL be counted 3 clk cycles after it is set up to clk, provided it lands in GATE; valid occurs GATE_CYCLES+1 cycles after the start cycle.
REQ-024 With GATE_CYCLES = clk frequency in Hz, freq SHALL read directly in Hz.

Reset
REQ-025 On rst=1: state=IDLE, s1=s2=s3=0, edge counter=0, gate counter=0, ovf=0, freq=0, valid=0, overflow=0, busy=0.
REQ-026 rst asserted mid-GATE SHALL abort the window with no valid pulse; freq is cleared to 0.
REQ-027 After rst deasserts, the block SHALL remain in IDLE until start=1 or continuous=1.

Verification (GATE_CYCLES=100, CNT_W=8 unless stated)
REQ-028 sig_in period 10 clk, start pulse -> valid once at cycle 101 after start, freq=10, overflow=0, then busy=0.
REQ-029 sig_in held at 0 or at 1 throughout, start -> freq=0, overflow=0.
REQ-030 CNT_W=4, sig_in period 4 clk (25 edges) -> freq=15, overflow=1; next window with period 20 -> freq=5, overflow=0.
REQ-031 continuous=1, period 5 -> valid every 101 cycles, each freq=20; drop continuous mid-window -> exactly one further valid, then IDLE.
REQ-032 rst pulse at cycle 50 of a window -> no valid, freq=0, busy=0; a later start gives a correct result.
REQ-033 start pulsed again during GATE -> ignored; exactly one valid; edge on the final GATE cycle counted, edge in DONE not counted.

Source files
------------

// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - control, status and measured-signal bundle for freq_meter
interface freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             sig_in;
    logic             start;
    logic             continuous;
    logic             busy;
    logic [CNT_W-1:0] freq;
    logic             valid;
    logic             overflow;

    modport master (
        output sig_in, start, continuous,
        input  busy, freq, valid, overflow
    );

    modport slave (
        input  sig_in, start, continuous,
        output busy, freq, valid, overflow
    );
endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge frequency counter
module freq_meter #(
    parameter logic [31:0] GATE_CYCLES = 32'd50_000_000,
    parameter int          CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    freq_meter_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GATE = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic             s1, s2, s3;
    logic [31:0]      gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             ovf;
    logic             ovf_nxt;
    logic [CNT_W-1:0] freq_q;
    logic             ovf_q;
    logic             rise;
    logic             last;

    assign rise = s2 & ~s3;
    assign last = (gate_cnt == GATE_CYCLES - 32'd1);

    // Synchronizer runs in every state so the first GATE cycle sees a valid edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= bus.sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf;
        if (rise) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + CNT_ONE;
            end
        end
    end

    // Results are captured on entry to DONE (including the final GATE cycle's edge)
    // so freq/overflow are already current while valid is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= 32'd0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            freq_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start || bus.continuous) begin
                        state    <= GATE;
                        gate_cnt <= 32'd0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end
                GATE: begin
                    gate_cnt <= gate_cnt + 32'd1;
                    edge_cnt <= edge_nxt;
                    ovf      <= ovf_nxt;
                    if (last) begin
                        state  <= DONE;
                        freq_q <= edge_nxt;
                        ovf_q  <= ovf_nxt;
                    end
                end
                DONE: begin
                    if (bus.continuous) begin
                        state    <= GATE;
                        gate_cnt <= 32'd0;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == GATE) || (state == DONE);
    assign bus.valid    = (state == DONE);
    assign bus.freq     = freq_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter against a waveform-history model
module tb_freq_meter;
    localparam int G = 100;

    logic clk;
    logic rst;

    freq_meter_if #(.CNT_W(8)) ifa ();
    freq_meter_if #(.CNT_W(4)) ifb ();

    freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    freq_meter #(.GATE_CYCLES(32'd100), .CNT_W(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    int cyc   = 0;
    int ncmp  = 0;
    int nfail = 0;
    int va    = 0;
    int vb    = 0;
    bit hist [0:16383];

    bit manual  = 1'b0;
    bit man_val = 1'b0;
    bit gen_val = 1'b0;
    bit level   = 1'b0;
    int mode    = 0;
    int per     = 10;
    int ph      = 0;

    assign ifa.sig_in = manual ? man_val : gen_val;
    assign ifb.sig_in = manual ? man_val : gen_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // hist[n] is the sig_in value seen at rising edge number n
    always @(posedge clk) begin
        if (cyc < 16384) hist[cyc] = ifa.sig_in;
        cyc = cyc + 1;
        if (ifa.valid === 1'b1) va = va + 1;
        if (ifb.valid === 1'b1) vb = vb + 1;
    end

    always @(negedge clk) begin
        case (mode)
            0: gen_val = level;
            1: begin
                gen_val = ((ph % per) < (per / 2));
                ph = ph + 1;
            end
            default: gen_val = 1'($urandom_range(0, 1));
        endcase
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp = ncmp + 1;
        assert (obs === exp) else begin
            nfail = nfail + 1;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Edges synchronised into a window starting at edge s are those with a 0->1 step
    // between sample j-1 and j, for j in [s-1, s+G-2] (two-flop synchronizer delay).
    function automatic int rises(input int lo, input int hi);
        int n = 0;
        for (int j = lo; j <= hi; j++)
            if (hist[j] && !hist[j-1]) n++;
        return n;
    endfunction

    task automatic run(input bit b, input string tag, input int lit_f, input int lit_o);
        int s, n, v0, mx, ef, eo;
        logic [31:0] f_obs, o_obs;
        s = cyc;
        if (b) ifb.start = 1'b1; else ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        chk({tag, " busy_in_gate"}, 32'(b ? ifb.busy : ifa.busy), 32'd1);
        v0 = b ? vb : va;
        wait_to(s + G + 1);
        n  = rises(s - 1, s + G - 2);
        mx = b ? 15 : 255;
        ef = (n > mx) ? mx : n;
        eo = (n > mx) ? 1 : 0;
        f_obs = b ? 32'(ifb.freq) : 32'(ifa.freq);
        o_obs = b ? 32'(ifb.overflow) : 32'(ifa.overflow);
        chk({tag, " valid"}, 32'(b ? ifb.valid : ifa.valid), 32'd1);
        chk({tag, " freq_model"}, f_obs, ef);
        chk({tag, " ovf_model"}, o_obs, eo);
        if (lit_f >= 0) begin
            chk({tag, " freq_lit"}, f_obs, lit_f);
            chk({tag, " ovf_lit"}, o_obs, lit_o);
        end
        @(negedge clk);
        chk({tag, " busy_after"}, 32'(b ? ifb.busy : ifa.busy), 32'd0);
        chk({tag, " valid_count"}, b ? vb : va, v0 + 1);
    endtask

    initial begin
        int s, v0, n, ws, c0;
        rst = 1'b1;
        ifa.start = 1'b0; ifa.continuous = 1'b0;
        ifb.start = 1'b0; ifb.continuous = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy_a", 32'(ifa.busy), 32'd0);
        chk("rst valid_a", 32'(ifa.valid), 32'd0);
        chk("rst freq_a", 32'(ifa.freq), 32'd0);
        chk("rst ovf_a", 32'(ifa.overflow), 32'd0);
        chk("rst busy_b", 32'(ifb.busy), 32'd0);
        chk("rst freq_b", 32'(ifb.freq), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_after_rst busy", 32'(ifa.busy), 32'd0);

        mode = 1; per = 10; ph = $urandom_range(0, 9);
        repeat (3) @(negedge clk);
        run(1'b0, "p10", 10, 0);

        mode = 0; level = 1'b0;
        repeat (3) @(negedge clk);
        run(1'b0, "level0", 0, 0);
        level = 1'b1;
        repeat (3) @(negedge clk);
        run(1'b0, "level1", 0, 0);

        mode = 1; per = 4; ph = $urandom_range(0, 3);
        repeat (3) @(negedge clk);
        run(1'b1, "b_p4_sat", 15, 1);
        per = 20; ph = $urandom_range(0, 19);
        repeat (3) @(negedge clk);
        run(1'b1, "b_p20", 5, 0);

        for (int i = 0; i < 3; i++) begin
            mode = 2;
            run(1'b0, $sformatf("rand_a%0d", i), -1, 0);
            run(1'b1, $sformatf("rand_b%0d", i), -1, 0);
            mode = 1; per = $urandom_range(2, 12); ph = $urandom_range(0, 11);
            repeat (2) @(negedge clk);
            run(1'b0, $sformatf("rper_a%0d", i), -1, 0);
        end

        mode = 1; per = 5; ph = $urandom_range(0, 4);
        repeat (3) @(negedge clk);
        s = cyc;
        v0 = va;
        ifa.continuous = 1'b1;
        for (int w = 0; w < 3; w++) begin
            ws = s + w * (G + 1);
            if (w == 2) begin
                wait_to(ws + 50);
                ifa.continuous = 1'b0;
            end
            wait_to(ws + G + 1);
            n = rises(ws - 1, ws + G - 2);
            chk($sformatf("cont%0d valid", w), 32'(ifa.valid), 32'd1);
            chk($sformatf("cont%0d freq_model", w), 32'(ifa.freq), n);
            chk($sformatf("cont%0d freq_lit", w), 32'(ifa.freq), 32'd20);
        end
        @(negedge clk);
        chk("cont busy_after", 32'(ifa.busy), 32'd0);
        repeat (150) @(negedge clk);
        chk("cont valid_count", va, v0 + 3);
        chk("cont still_idle", 32'(ifa.busy), 32'd0);

        per = 10; ph = 0;
        repeat (3) @(negedge clk);
        s = cyc;
        v0 = va;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_to(s + 50);
        rst = 1'b1;
        #1;
        chk("midrst busy", 32'(ifa.busy), 32'd0);
        chk("midrst freq", 32'(ifa.freq), 32'd0);
        chk("midrst valid", 32'(ifa.valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_to(s + G + 10);
        chk("midrst no_valid", va, v0);
        chk("midrst idle", 32'(ifa.busy), 32'd0);
        run(1'b0, "after_rst", 10, 0);

        manual = 1'b1;
        man_val = 1'b0;
        repeat (4) @(negedge clk);
        man_val = 1'b1;
        @(negedge clk);
        man_val = 1'b0;
        s = cyc;
        v0 = va;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_to(s + 30);
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_to(s + G - 2);
        man_val = 1'b1;
        @(negedge clk);
        man_val = 1'b0;
        wait_to(s + G + 1);
        chk("edges_first_last freq_lit", 32'(ifa.freq), 32'd2);
        chk("edges_first_last freq_model", 32'(ifa.freq), rises(s - 1, s + G - 2));
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        chk("start_in_done busy", 32'(ifa.busy), 32'd0);
        repeat (5) @(negedge clk);
        chk("start_ignored idle", 32'(ifa.busy), 32'd0);
        chk("start_ignored valid_count", va, v0 + 1);

        repeat (3) @(negedge clk);
        c0 = cyc;
        man_val = 1'b1;
        @(negedge clk);
        man_val = 1'b0;
        @(negedge clk);
        s = cyc;
        ifa.start = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        wait_to(s + G - 1);
        man_val = 1'b1;
        wait_to(s + G + 1);
        chk("edge_pre_and_done freq_lit", 32'(ifa.freq), 32'd0);
        chk("edge_pre_and_done freq_model", 32'(ifa.freq), rises(s - 1, s + G - 2));
        chk("edge_pre_and_done valid", 32'(ifa.valid), 32'd1);
        if (c0 < 0) chk("c0", 32'd0, 32'd1);
        manual = 1'b0;

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
